// File: rtl/case_6_mul_arbiter.sv
// ----------------------------------------------------------------------------
// case_6_mul_arbiter
//
// Round-robin front end for one shared signed multiplier (DIN0_WIDTH x
// DIN1_WIDTH, low DOUT_WIDTH bits of the product kept). Requesters offer
// operand pairs over valid/ready. The block feeds a registered pipeline of
// MUL_STAGES stages and returns each product tagged with its requester index.
//
// Ports:
//   ap_clk     in   1                      rising-edge clock
//   ap_rst_n   in   1                      synchronous active-low reset
//   req_valid  in   NUM_REQ                per-requester operand valid
//   req_ready  out  NUM_REQ                per-requester accept (one-hot or 0)
//   req_a      in   NUM_REQ*DIN0_WIDTH     operand A, requester i at [i*DIN0_WIDTH +: DIN0_WIDTH]
//   req_b      in   NUM_REQ*DIN1_WIDTH     operand B, packed the same way
//   rsp_valid  out  1                      result valid (last stage valid)
//   rsp_ready  in   1                      downstream accept
//   rsp_data   out  DOUT_WIDTH             truncated signed product
//   rsp_id     out  ID_W                   issuing requester index
//   busy       out  1                      any pipeline stage holds a valid entry
// ----------------------------------------------------------------------------
module case_6_mul_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DIN0_WIDTH = 12,
    parameter int DIN1_WIDTH = 9,
    parameter int DOUT_WIDTH = 12,
    parameter int MUL_STAGES = 2,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                             ap_clk,
    input  logic                             ap_rst_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*DIN0_WIDTH-1:0]    req_a,
    input  logic [NUM_REQ*DIN1_WIDTH-1:0]    req_b,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [DOUT_WIDTH-1:0]            rsp_data,
    output logic [ID_W-1:0]                  rsp_id,
    output logic                             busy
);

    localparam int PROD_W = DIN0_WIDTH + DIN1_WIDTH;
    localparam int LAST   = MUL_STAGES - 1;

    // Full-width signed product, truncated to the result width (no saturation).
    function automatic logic [DOUT_WIDTH-1:0] mul_trunc(
        input logic signed [DIN0_WIDTH-1:0] a,
        input logic signed [DIN1_WIDTH-1:0] b
    );
        logic signed [PROD_W-1:0] p;
        p = a * b;
        return p[DOUT_WIDTH-1:0];
    endfunction

    logic [MUL_STAGES-1:0]          valid_r;
    logic [ID_W-1:0]                id_r [MUL_STAGES];
    logic [ID_W-1:0]                ptr_r;

    logic                           stall_s;
    logic                           found_s;
    logic                           accept_s;
    logic [ID_W-1:0]                grant_s;
    logic [ID_W-1:0]                idx_s;
    logic signed [DIN0_WIDTH-1:0]   sel_a_s;
    logic signed [DIN1_WIDTH-1:0]   sel_b_s;

    // A full last stage that downstream refuses freezes the whole pipeline.
    assign stall_s = valid_r[LAST] & ~rsp_ready;

    // Round-robin scan starting at ptr_r; first valid index wins.
    always_comb begin
        found_s = 1'b0;
        grant_s = '0;
        idx_s   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_s = ID_W'((int'(ptr_r) + i) % NUM_REQ);
            if (!found_s && req_valid[idx_s]) begin
                found_s = 1'b1;
                grant_s = idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // One-hot ready for the granted requester; held low in reset and on stall.
    always_comb begin
        req_ready = '0;
        if (ap_rst_n && !stall_s && found_s) begin
            req_ready[grant_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    assign accept_s = |(req_ready & req_valid);

    // Operand mux driven only by the grant, so operands never feed req_ready.
    assign sel_a_s = req_a[int'(grant_s)*DIN0_WIDTH +: DIN0_WIDTH];
    assign sel_b_s = req_b[int'(grant_s)*DIN1_WIDTH +: DIN1_WIDTH];

    // Valid/tag pipeline and arbitration pointer.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            valid_r <= '0;
            ptr_r   <= '0;
            for (int k = 0; k < MUL_STAGES; k++) begin
                id_r[k] <= '0;
            end
        end else if (!stall_s) begin
            // Bubbles advance too: stage 0 takes valid=0 when nothing is accepted.
            valid_r[0] <= accept_s;
            id_r[0]    <= grant_s;
            for (int k = 1; k < MUL_STAGES; k++) begin
                valid_r[k] <= valid_r[k-1];
                id_r[k]    <= id_r[k-1];
            end
            if (accept_s) begin
                ptr_r <= (int'(grant_s) == NUM_REQ - 1) ? '0 : grant_s + 1'b1;
            end
        end
    end

    generate
        if (MUL_STAGES == 1) begin : g_single
            // With one stage the operand register and the result register coincide,
            // so the product is formed in front of it.
            logic [DOUT_WIDTH-1:0] prod_r;

            // Single result register.
            always_ff @(posedge ap_clk) begin
                if (!ap_rst_n) begin
                    prod_r <= '0;
                end else if (!stall_s) begin
                    prod_r <= mul_trunc(sel_a_s, sel_b_s);
                end
            end

            assign rsp_data = prod_r;
        end else begin : g_multi
            logic signed [DIN0_WIDTH-1:0] op_a_r;
            logic signed [DIN1_WIDTH-1:0] op_b_r;
            logic [DOUT_WIDTH-1:0]        prod_r [1:MUL_STAGES-1];

            // Stage 0 holds operands; stage 1 holds the product; later stages delay it.
            always_ff @(posedge ap_clk) begin
                if (!ap_rst_n) begin
                    op_a_r <= '0;
                    op_b_r <= '0;
                    for (int k = 1; k < MUL_STAGES; k++) begin
                        prod_r[k] <= '0;
                    end
                end else if (!stall_s) begin
                    op_a_r    <= sel_a_s;
                    op_b_r    <= sel_b_s;
                    prod_r[1] <= mul_trunc(op_a_r, op_b_r);
                    for (int k = 2; k < MUL_STAGES; k++) begin
                        prod_r[k] <= prod_r[k-1];
                    end
                end
            end

            assign rsp_data = prod_r[LAST];
        end
    endgenerate

    assign rsp_valid = valid_r[LAST];
    assign rsp_id    = id_r[LAST];
    assign busy      = |valid_r;

endmodule
